// File: rtl/cond_exec_unit_if.sv
// Decode-to-execute control bundle for cond_exec_unit: decoder controls and ALU flags in,
// condition-gated write enables, flags and squash count out.
interface cond_exec_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             valid_d;
  logic [3:0]       cond_d;
  logic             pcs_d;
  logic             regw_d;
  logic             memw_d;
  logic [1:0]       flagw_d;
  logic             stall;
  logic             flush;
  logic [3:0]       alu_flags;
  logic             pc_src;
  logic             reg_write;
  logic             mem_write;
  logic             cond_ex;
  logic [3:0]       flags;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output valid_d, cond_d, pcs_d, regw_d, memw_d, flagw_d, stall, flush, alu_flags,
    input  pc_src, reg_write, mem_write, cond_ex, flags, squash_cnt
  );

  modport slave (
    input  valid_d, cond_d, pcs_d, regw_d, memw_d, flagw_d, stall, flush, alu_flags,
    output pc_src, reg_write, mem_write, cond_ex, flags, squash_cnt
  );
endinterface

// File: rtl/cond_exec_unit.sv
// Execute-stage condition unit: E-slot register with stall/flush, NZCV flags, ARM condition
// evaluation, condition-gated write enables and a saturating squashed-instruction counter.
module cond_exec_unit #(
  parameter logic [3:0]  FLAG_INIT = 4'b0000,
  parameter int unsigned CNT_W     = 16
) (
  input logic              clk,
  input logic              reset,
  cond_exec_unit_if.slave  bus
);

  logic             valid_e_q;
  logic [3:0]       cond_e_q;
  logic             pcs_e_q;
  logic             regw_e_q;
  logic             memw_e_q;
  logic [1:0]       flagw_e_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;

  logic n, z, c, v;
  logic pass;
  logic cond_ex;
  logic commit;
  logic squash;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    pass = 1'b0;
    case (cond_e_q)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;  // reserved encoding never executes
    endcase
  end

  assign cond_ex = valid_e_q & pass;
  // A stalled instruction must not commit yet; it commits once, on its first free cycle.
  assign commit  = cond_ex & ~bus.stall;
  assign squash  = valid_e_q & ~pass & ~bus.stall;

  assign bus.cond_ex    = cond_ex;
  assign bus.pc_src     = commit & pcs_e_q;
  assign bus.reg_write  = commit & regw_e_q;
  assign bus.mem_write  = commit & memw_e_q;
  assign bus.flags      = flags_q;
  assign bus.squash_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_e_q <= 1'b0;
      cond_e_q  <= 4'b0000;
      pcs_e_q   <= 1'b0;
      regw_e_q  <= 1'b0;
      memw_e_q  <= 1'b0;
      flagw_e_q <= 2'b00;
      flags_q   <= FLAG_INIT;
      cnt_q     <= '0;
    end else begin
      if (bus.flush) begin
        valid_e_q <= 1'b0;
        cond_e_q  <= 4'b0000;
        pcs_e_q   <= 1'b0;
        regw_e_q  <= 1'b0;
        memw_e_q  <= 1'b0;
        flagw_e_q <= 2'b00;
      end else if (!bus.stall) begin
        valid_e_q <= bus.valid_d;
        cond_e_q  <= bus.cond_d;
        pcs_e_q   <= bus.pcs_d;
        regw_e_q  <= bus.regw_d;
        memw_e_q  <= bus.memw_d;
        flagw_e_q <= bus.flagw_d;
      end
      // The outgoing instruction still retires its flags when the slot is flushed behind it.
      if (commit && flagw_e_q[1]) flags_q[3:2] <= bus.alu_flags[3:2];
      if (commit && flagw_e_q[0]) flags_q[1:0] <= bus.alu_flags[1:0];
      if (squash && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: directed scenarios then random stimulus, checked
// against a behavioural model; a 16-bit and a 2-bit counter instance share the stimulus.
module tb_cond_exec_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_exec_unit_if #(.CNT_W(16)) bus16 ();
  cond_exec_unit_if #(.CNT_W(2))  bus2 ();

  cond_exec_unit #(.FLAG_INIT(4'b0000), .CNT_W(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  cond_exec_unit #(.FLAG_INIT(4'b0000), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       cond_ex;
    logic [3:0] flags;
    int         cnt16;
    int         cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: the instruction sitting in E plus architectural flags and counters.
  bit         m_known = 0;
  bit         m_valid;
  logic [3:0] m_cond;
  bit         m_pcs, m_regw, m_memw;
  logic [1:0] m_flagw;
  logic [3:0] m_flags;
  int         m_cnt16, m_cnt2;

  // ARM encoding: bits [3:1] pick a base test, bit 0 inverts it; 1111 never executes.
  function automatic bit cpass(logic [3:0] c, logic [3:0] f);
    bit nf = f[3];
    bit zf = f[2];
    bit cf = f[1];
    bit vf = f[0];
    bit r  = 1'b0;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: r = zf;
      3'd1: r = cf;
      3'd2: r = nf;
      3'd3: r = vf;
      3'd4: r = cf && !zf;
      3'd5: r = (nf == vf);
      3'd6: r = !zf && (nf == vf);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step(bit rst, bit vld, logic [3:0] cnd, bit pcs, bit regw, bit memw,
                      logic [1:0] fw, bit stl, bit fls, logic [3:0] alu);
    exp_t e;
    bit   ok;
    @(posedge clk);
    #1;
    reset = rst;
    bus16.valid_d = vld;  bus2.valid_d = vld;
    bus16.cond_d  = cnd;  bus2.cond_d  = cnd;
    bus16.pcs_d   = pcs;  bus2.pcs_d   = pcs;
    bus16.regw_d  = regw; bus2.regw_d  = regw;
    bus16.memw_d  = memw; bus2.memw_d  = memw;
    bus16.flagw_d = fw;   bus2.flagw_d = fw;
    bus16.stall   = stl;  bus2.stall   = stl;
    bus16.flush   = fls;  bus2.flush   = fls;
    bus16.alu_flags = alu; bus2.alu_flags = alu;
    if (m_known) begin
      ok          = m_valid && cpass(m_cond, m_flags);
      e.cond_ex   = ok;
      e.pc_src    = ok && !stl && m_pcs;
      e.reg_write = ok && !stl && m_regw;
      e.mem_write = ok && !stl && m_memw;
      e.flags     = m_flags;
      e.cnt16     = m_cnt16;
      e.cnt2      = m_cnt2;
      exp_q.push_back(e);
    end
    // Advance the model to the state after the coming edge.
    if (rst) begin
      m_known = 1; m_valid = 0; m_cond = 0; m_pcs = 0; m_regw = 0; m_memw = 0;
      m_flagw = 0; m_flags = 4'b0000; m_cnt16 = 0; m_cnt2 = 0;
    end else begin
      ok = m_valid && cpass(m_cond, m_flags);
      if (ok && !stl) begin
        if (m_flagw[1]) m_flags[3:2] = alu[3:2];
        if (m_flagw[0]) m_flags[1:0] = alu[1:0];
      end
      if (m_valid && !ok && !stl) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (fls) begin
        m_valid = 0; m_cond = 0; m_pcs = 0; m_regw = 0; m_memw = 0; m_flagw = 0;
      end else if (!stl) begin
        m_valid = vld; m_cond = cnd; m_pcs = pcs; m_regw = regw; m_memw = memw; m_flagw = fw;
      end
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_src",       32'(bus16.pc_src),     32'(e.pc_src));
        chk("reg_write",    32'(bus16.reg_write),  32'(e.reg_write));
        chk("mem_write",    32'(bus16.mem_write),  32'(e.mem_write));
        chk("cond_ex",      32'(bus16.cond_ex),    32'(e.cond_ex));
        chk("flags",        32'(bus16.flags),      32'(e.flags));
        chk("squash_cnt16", 32'(bus16.squash_cnt), 32'(e.cnt16));
        chk("squash_cnt2",  32'(bus2.squash_cnt),  32'(e.cnt2));
        chk("cond_ex_w2",   32'(bus2.cond_ex),     32'(e.cond_ex));
      end
    end
  end

  initial begin
    int wait_cyc;
    reset = 1'b1;
    // Reset, then an AL register write.
    step(1, 0, 4'h0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
    step(0, 1, 4'hE, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    // SUBS setting Z, then EQ (passes) and NE (squashed).
    step(0, 1, 4'hE, 0, 0, 0, 2'b11, 0, 0, 4'h0);
    step(0, 1, 4'h0, 0, 1, 0, 2'b00, 0, 0, 4'h4);
    step(0, 1, 4'h1, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    // Set flags to 1001, then GE LT GT LE and the reserved code.
    step(0, 1, 4'hE, 0, 0, 0, 2'b11, 0, 0, 4'h0);
    step(0, 1, 4'hA, 0, 1, 0, 2'b00, 0, 0, 4'h9);
    step(0, 1, 4'hB, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    step(0, 1, 4'hC, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    step(0, 1, 4'hD, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    step(0, 1, 4'hF, 1, 1, 1, 2'b11, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 0, 2'b00, 0, 0, 4'hF);
    // Memory write with N,Z update held by a 3-cycle stall.
    step(0, 1, 4'hE, 1, 0, 1, 2'b10, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 4'h0, 0, 1, 0, 2'b00, 1, 0, 4'hC);
    step(0, 0, 4'h0, 0, 0, 0, 2'b00, 0, 0, 4'hC);
    step(0, 0, 4'h0, 0, 0, 0, 2'b00, 0, 0, 4'h3);
    // Flush together with stall on a failing instruction.
    step(0, 1, 4'h1, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    step(0, 1, 4'hE, 0, 1, 0, 2'b00, 1, 1, 4'h0);
    step(0, 0, 4'h0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
    // Five failing instructions saturate the 2-bit counter; reset mid-sequence.
    for (int i = 0; i < 5; i++) step(0, 1, 4'hF, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    step(0, 1, 4'hF, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    step(1, 1, 4'hF, 0, 1, 0, 2'b11, 0, 0, 4'hF);
    for (int i = 0; i < 3; i++) step(0, 1, 4'hF, 0, 1, 0, 2'b00, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 4'($urandom()),
           1'($urandom()), 1'($urandom()), 1'($urandom()), 2'($urandom()),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 4'($urandom()));
    end
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
